// File: rtl/prio_irq_encoder_pkg.sv
// Shared encodings for the registered priority interrupt encoder.
package prio_irq_encoder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_irq_encoder_prio_find.sv
// Combinational search for the first set bit of vec at or above start,
// wrapping from N-1 back to 0.
module prio_find #(
  parameter int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] hi_idx;
  logic [W-1:0] lo_idx;
  logic         hi_any;
  logic         lo_any;

  // Scanning downward lets the last hit be the lowest index in each window.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    lo_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        lo_idx = W'(i);
        lo_any = 1'b1;
        if (i >= int'(start)) begin
          hi_idx = W'(i);
          hi_any = 1'b1;
        end
      end
    end
    idx   = hi_any ? hi_idx : lo_idx;
    found = lo_any;
  end

endmodule

// File: rtl/prio_irq_encoder.sv
// Registered N-line priority encoder: pending latch, per-line mask, fixed or
// round-robin selection, and a held grant with a valid/ack handshake.
module prio_irq_encoder
  import prio_irq_encoder_pkg::*;
#(
  parameter int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic [N-1:0] mask,
  input  logic         mode,
  input  logic         ack,
  output logic [W-1:0] code,
  output logic         valid
);

  // Handshake: valid=1 presents code until the consumer raises ack at a
  // rising edge; that edge retires the grant. ack with valid=0 is ignored.
  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] code_q, code_d;
  logic         valid_q, valid_d;

  logic [N-1:0] clr;
  logic [N-1:0] eligible;
  logic [W-1:0] start;
  logic [W-1:0] sel_idx;
  logic         sel_found;

  assign eligible = pending_q & ~mask;
  assign start    = (mode == MODE_RR) ? ptr_q : '0;

  prio_find #(.N(N)) u_find (
    .vec   (eligible),
    .start (start),
    .idx   (sel_idx),
    .found (sel_found)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    code_d  = code_q;
    valid_d = valid_q;
    clr     = '0;

    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          code_d  = sel_idx;
          valid_d = 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (ack) begin
          clr     = {{(N-1){1'b0}}, 1'b1} << code_q;
          valid_d = 1'b0;
          state_d = ST_IDLE;
          if (mode == MODE_RR) begin
            ptr_d = (code_q == W'(N - 1)) ? '0 : code_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // A fresh request for the line being cleared keeps it pending.
    pending_d = (pending_q & ~clr) | in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      ptr_q     <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
    end
  end

  assign code  = code_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_prio_irq_encoder.sv
// Directed bench for prio_irq_encoder (N=8): table of per-cycle vectors plus
// hand-written multi-cycle sequences.
module tb_prio_irq_encoder;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in;
  logic [N-1:0] mask;
  logic         mode;
  logic         ack;
  logic [W-1:0] code;
  logic         valid;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [N-1:0] in_v;
    logic [N-1:0] mask_v;
    logic         mode_v;
    logic         ack_v;
    logic         exp_valid;
    logic [W-1:0] exp_code;
  } vec_t;

  vec_t vecs[$];

  prio_irq_encoder #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .mask  (mask),
    .mode  (mode),
    .ack   (ack),
    .code  (code),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic add_vec(input logic [N-1:0] i, input logic [N-1:0] m,
                         input logic md, input logic a,
                         input logic ev, input logic [W-1:0] ec);
    vec_t v;
    v.in_v = i; v.mask_v = m; v.mode_v = md; v.ack_v = a;
    v.exp_valid = ev; v.exp_code = ec;
    vecs.push_back(v);
  endtask

  task automatic drive_step(input logic [N-1:0] i, input logic [N-1:0] m,
                            input logic md, input logic a, input logic r);
    in = i; mask = m; mode = md; ack = a; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag, input int idx,
                         input logic ev, input logic [W-1:0] ec);
    n_checks++;
    if (valid === ev && code === ec) begin
      n_pass++;
    end else begin
      $display("FAIL %s[%0d]: valid=%b code=%0d, want valid=%b code=%0d",
               tag, idx, valid, code, ev, ec);
    end
  endtask

  task automatic step_check(input string tag, input int idx,
                            input logic [N-1:0] i, input logic [N-1:0] m,
                            input logic md, input logic a, input logic r,
                            input logic ev, input logic [W-1:0] ec);
    drive_step(i, m, md, a, r);
    compare(tag, idx, ev, ec);
  endtask

  initial begin
    rst = 1'b1; in = 8'hFF; mask = '0; mode = 1'b0; ack = 1'b0;

    // Reset held two cycles with every line requesting.
    for (int k = 0; k < 2; k++) step_check("reset", k, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) step_check("post_reset", k, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Fixed priority: lines 5 and 7 pulsed together.
    add_vec(8'hA0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    add_vec(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5);
    add_vec(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5);
    add_vec(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd5);
    add_vec(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7);
    add_vec(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd7);
    add_vec(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd7);
    add_vec(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd7);
    // Round-robin with lines 0 and 7 held: alternates 0,7,0,7.
    add_vec(8'h81, 8'h00, 1'b1, 1'b0, 1'b0, 3'd7);
    add_vec(8'h81, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0);
    add_vec(8'h81, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0);
    add_vec(8'h81, 8'h00, 1'b1, 1'b0, 1'b1, 3'd7);
    add_vec(8'h81, 8'h00, 1'b1, 1'b1, 1'b0, 3'd7);
    add_vec(8'h81, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0);
    add_vec(8'h81, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0);
    add_vec(8'h81, 8'h00, 1'b1, 1'b0, 1'b1, 3'd7);
    add_vec(8'h81, 8'h00, 1'b1, 1'b1, 1'b0, 3'd7);
    // Fixed with the same held lines: always 0.
    add_vec(8'h81, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0);
    add_vec(8'h81, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0);
    add_vec(8'h81, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0);
    add_vec(8'h81, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0);
    add_vec(8'h81, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0);
    add_vec(8'h81, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0);
    // Drain the pending 0 and 7.
    add_vec(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0);
    add_vec(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0);
    add_vec(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7);
    add_vec(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd7);
    add_vec(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd7);

    foreach (vecs[k]) begin
      step_check("table", k, vecs[k].in_v, vecs[k].mask_v, vecs[k].mode_v,
                 vecs[k].ack_v, 1'b0, vecs[k].exp_valid, vecs[k].exp_code);
    end

    // Masked line stays pending but is never granted until unmasked.
    step_check("mask", 0, 8'h04, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7);
    for (int k = 1; k <= 10; k++) step_check("mask", k, 8'h00, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7);
    drive_step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step_check("mask_clear", 0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    step_check("mask_clear", 1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
    step_check("mask_clear", 2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);

    // Grant lock: line 4 outstanding while higher-priority line 1 arrives.
    step_check("lock", 0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    step_check("lock", 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
    step_check("lock", 2, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
    for (int k = 3; k < 7; k++) step_check("lock", k, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
    step_check("lock", 7, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4);
    step_check("lock", 8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    step_check("lock", 9, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);

    // ack while idle changes nothing.
    for (int k = 0; k < 3; k++) step_check("idle_ack", k, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);

    // ack for line 3 coinciding with a new request on line 3.
    step_check("reack", 0, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    step_check("reack", 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
    step_check("reack", 2, 8'h08, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
    step_check("reack", 3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
    step_check("reack", 4, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
    step_check("reack", 5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);

    // Reset during an outstanding grant clears pending lines too.
    step_check("rst_grant", 0, 8'h21, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    step_check("rst_grant", 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    step_check("rst_grant", 2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    for (int k = 3; k < 6; k++) step_check("rst_grant", k, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prio_irq_encoder.md
Name: prio_irq_encoder

Overview:
- Parametrised, registered successor to the team's combinational 8-input priority encoder.
- Latches N request lines into a pending register and applies a per-line mask.
- Selects one pending line by fixed (LSB-first) or round-robin priority and holds it as a granted code with a valid/ack handshake until the consumer accepts it.
- Sits between raw request/interrupt sources and a single serial consumer (controller FSM or CPU-side handler).

Parameters:
- N, 8, number of request lines; legal range 2..64.
- W, $clog2(N), width of the code output; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  N  request lines; bit i high at a rising edge sets pending[i].
- mask  input  N  bit i high makes line i ineligible for selection; pending[i] is still set and kept.
- mode  input  1  0 = fixed priority (index 0 highest); 1 = round-robin.
- ack  input  1  consumer accepts the current grant; ignored while valid=0.
- code  output  W  index of the granted line; registered.
- valid  output  1  code holds a grant awaiting ack; registered.

Behaviour:
- Reset (rst high at an edge): pending=0, ptr=0, state=IDLE, valid=0, code=0. Reset overrides every other input.
- Unlike the older encoder, code never drives x. When valid=0, code holds its last value; after reset that value is 0.
- pending update every edge: pending <= (pending & ~clr) | in, where clr is one-hot(code) when state=GRANT and ack=1, otherwise 0.
- If a new request and a clear for the same bit arrive at the same edge, the request wins and the bit stays pending.
- eligible = pending & ~mask.
- State IDLE:
  - If eligible != 0: code <= selected index, valid <= 1, go to GRANT.
  - Otherwise stay in IDLE with valid=0.
- State GRANT:
  - code and valid are frozen until ack. New higher-priority requests or mask changes do not alter code.
  - On ack: valid <= 0, go to IDLE. In round-robin mode, ptr <= (code+1) mod N.
- Selection:
  - mode=0: lowest set index of eligible.
  - mode=1: first set index of eligible at or above ptr, wrapping from N-1 to 0.
  - ptr advances only on an accepted grant in mode=1, and is retained when mode changes.
- Latency:
  - A request sampled at edge k appears in pending after edge k.
  - valid=1 with its code appears after edge k+1, so latency is 2 cycles.
- Throughput: at most one grant per 2 cycles, because IDLE always lasts at least one cycle after an ack.
- A granted line that becomes masked during GRANT is still delivered.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=1'b0, ST_GRANT=1'b1) and the mode encodings (MODE_FIXED=0, MODE_RR=1).
- One sub-module, prio_find:
  - Purely combinational.
  - Parameter N; inputs vec[N-1:0] and start[W-1:0]; outputs idx[W-1:0] and found.
  - Finds the first set bit at or above start, with wrap.
  - Fixed mode reuses it with start=0.
- The top module holds the pending register, ptr, FSM and output registers.

Test Plan (N=8):
- Reset: hold rst for 2 cycles with in=8'hFF, then release with in=0 → valid=0, code=0, no grant ever appears.
- Fixed priority:
  - Stimulus: mode=0, pulse in=8'b1010_0000 for one cycle.
  - valid=1 with code=5 two edges later.
  - ack → valid=0 for one cycle, then code=7.
  - ack → valid stays 0.
- Round-robin vs fixed:
  - Stimulus: hold in=8'b1000_0001, ack each grant.
  - mode=1: grants 0,7,0,7.
  - mode=0: grants 0,0,0.
- Mask:
  - Stimulus: mask=8'b0000_0100, pulse in[2].
  - valid stays 0 for 10 cycles.
  - Clear mask → code=2 with valid=1 two edges later.
- Grant lock:
  - Stimulus: grant code=4 outstanding, then pulse in[1], hold ack low for 5 cycles.
  - code stays 4 throughout.
  - ack → next grant is code=1.
- Handshake edges:
  - ack while valid=0 → no state change.
  - ack for code=3 at the same edge as in[3]=1 → line 3 is re-granted after the IDLE cycle.
  - rst mid-GRANT → valid=0 next cycle and pending cleared.
